// File: rtl/chunk_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// chunk_serial_adder_pkg
//   Shared declarations for the chunk-serial adder:
//     csa_state_e : FSM state encoding (IDLE / RUN / DONE)
//     cnt_width() : width of the chunk index counter for a given chunk count
// ---------------------------------------------------------------------------
package chunk_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder_nbit.sv
// ---------------------------------------------------------------------------
// full_adder_nbit
//   Combinational WIDTH-bit adder with carry in and carry out.
//   Ports:
//     a, b  [WIDTH-1:0]  addends
//     cin                carry-in
//     s     [WIDTH-1:0]  sum
//     cout               carry-out
// ---------------------------------------------------------------------------
module full_adder_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] sum_full;

    assign sum_full = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
    assign s        = sum_full[WIDTH-1:0];
    assign cout     = sum_full[WIDTH];

endmodule

// File: rtl/chunk_serial_adder.sv
// ---------------------------------------------------------------------------
// chunk_serial_adder
//   Adds two WIDTH-bit operands CHUNK bits per cycle using one shared
//   CHUNK-bit adder. An operation takes WIDTH/CHUNK RUN cycles, then the
//   result is held in DONE until the consumer takes it.
//
//   Parameters:
//     WIDTH  operand / sum width (must be a multiple of CHUNK)
//     CHUNK  bits added per cycle
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   operand handshake (a, b, cin)
//     a, b [WIDTH-1:0]    addends
//     cin                 carry-in
//     sub                 subtract select (only with CHUNK_SERIAL_ADDER_SUB_EN)
//     out_valid/out_ready result handshake (s, cout)
//     s [WIDTH-1:0]       sum, meaningful only while out_valid=1
//     cout                carry-out, 0 outside DONE
//     busy                operation in progress or result pending
//
//   Optional feature macro: CHUNK_SERIAL_ADDER_SUB_EN adds the sub input and
//   computes a - b - cin as a + ~b + !cin (cout=1 means no borrow).
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both 1. in_ready is 1 only in IDLE, so operands offered in RUN
//   or DONE are ignored. Once out_valid rises, s/cout/out_valid stay stable
//   until the edge where out_ready is also 1.
// ---------------------------------------------------------------------------
module chunk_serial_adder
    import chunk_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunk_serial_adder: WIDTH must be an integer multiple of CHUNK");
    end

    csa_state_e        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [31:0]       shift_amt;
    logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_s;
    logic              chunk_cout;

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and the incoming borrow, so the
    // same adder path produces a + ~b + !cin.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Select chunk k of the captured operands by shifting it down to bit 0.
    assign shift_amt = 32'(cnt_q) * 32'(CHUNK);
    assign chunk_a   = CHUNK'(a_q >> shift_amt);
    assign chunk_b   = CHUNK'(b_q >> shift_amt);

    full_adder_nbit #(
        .WIDTH (CHUNK)
    ) u_fa (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    cnt_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // s was cleared on accept, so OR-ing places chunk k in place.
                s_d     = s_q | (WIDTH'(chunk_s) << shift_amt);
                carry_d = chunk_cout;
                if (cnt_q == LAST_IDX) begin
                    cout_d  = chunk_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    cout_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_chunk_serial_adder
//   Directed bench for chunk_serial_adder (WIDTH=16, CHUNK=4). A cycle-level
//   model (operation phases plus plain a+b+cin arithmetic) is checked against
//   the DUT on every falling edge; driver tasks add literal expectations.
// ---------------------------------------------------------------------------
module tb_chunk_serial_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;

    chunk_serial_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .busy      (busy)
    );

    // ---------------- check bookkeeping ----------------
    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    // Phases: 0 idle, 1 computing (m_left cycles to go), 2 result held.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic [WIDTH:0] exp_q[$];
    int             m_state = M_IDLE;
    int             m_left  = 0;
    bit             mon_en  = 1'b0;

    function automatic logic [WIDTH:0] model_result(input logic [WIDTH-1:0] av, bv,
                                                    input logic cv, sv);
        if (sv)
            return (WIDTH+1)'(av) + (WIDTH+1)'(~bv) + (WIDTH+1)'(!cv);
        else
            return (WIDTH+1)'(av) + (WIDTH+1)'(bv) + (WIDTH+1)'(cv);
    endfunction

    // Inputs only change just after a rising edge, so what is seen on the
    // falling edge is exactly what the next rising edge will sample.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_state = M_IDLE;
                exp_q.delete();
            end
            check("mon in_ready",  32'(in_ready),  32'(m_state == M_IDLE));
            check("mon out_valid", 32'(out_valid), 32'(m_state == M_DONE));
            check("mon busy",      32'(busy),      32'(m_state != M_IDLE));
            if (m_state == M_DONE) begin
                if (exp_q.size() == 0) check("mon model queue", 32'(0), 32'(1));
                else                   check("mon result", 32'({cout, s}), 32'(exp_q[0]));
            end else begin
                check("mon cout idle", 32'(cout), 32'(0));
            end
            if (rst_n) begin
                case (m_state)
                    M_IDLE: if (in_valid) begin
                        exp_q.push_back(model_result(a, b, cin, sub));
                        m_left  = N;
                        m_state = M_RUN;
                    end
                    M_RUN: begin
                        m_left--;
                        if (m_left == 0) m_state = M_DONE;
                    end
                    M_DONE: if (out_ready) begin
                        void'(exp_q.pop_front());
                        m_state = M_IDLE;
                    end
                    default: m_state = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv,
                         input logic [WIDTH:0] exp_lit, input string name);
        bit seen;
        int lat;
        @(posedge clk); #1;
        a = av; b = bv; cin = cv; sub = sv;
        in_valid = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) seen = 1'b1;
        end
        check({name, " accept"}, 32'(seen), 32'(1));
        @(posedge clk); #1;
        // Scramble the inputs: the result must come from the captured copy.
        in_valid = 1'b0;
        a   = WIDTH'($urandom_range(0, 65535));
        b   = WIDTH'($urandom_range(0, 65535));
        cin = 1'($urandom_range(0, 1));
        sub = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(N));
        check({name, " result"}, 32'({cout, s}), 32'(exp_lit));
        @(posedge clk); #1;
        check({name, " in_ready after handshake"}, 32'(in_ready), 32'(1));
        check({name, " out_valid after handshake"}, 32'(out_valid), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    int dones;
    bit seen_v;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(in_ready),  32'(1));
        check("reset out_valid", 32'(out_valid), 32'(0));
        check("reset busy",      32'(busy),      32'(0));
        check("reset s",         32'(s),         32'(0));
        check("reset cout",      32'(cout),      32'(0));
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic additions, carry ripple across every chunk, all-ones.
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, "add_1234_4321");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, "add_ffff_0001");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, "add_ffff_ffff_c1");
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001, "add_zero_c1");
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, "add_msb_carry");
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, "add_mid_carry");
        do_op(16'hABCD, 16'h1234, 1'b1, 1'b0, 17'h0BE02, "add_abcd_1234_c1");

        // Consumer stalls for 5 cycles in DONE; a new operand pulse must be ignored.
        @(posedge clk); #1;
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen_v = 1'b0;
        for (int i = 0; i < 20 && !seen_v; i++) begin
            if (out_valid === 1'b1) seen_v = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("stall reached done", 32'(seen_v), 32'(1));
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", 32'(out_valid), 32'(1));
            check("stall in_ready",  32'(in_ready),  32'(0));
            check("stall result",    32'({cout, s}), 32'(17'h01000));
            if (i == 1) begin in_valid = 1'b1; a = 16'h0001; b = 16'h0001; end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall release in_ready",  32'(in_ready),  32'(1));
        check("stall release out_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check("stall pulse ignored busy", 32'(busy), 32'(0));

        // Reset during the second RUN cycle discards the operation.
        a = 16'h7777; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre-reset busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async reset in_ready",  32'(in_ready),  32'(1));
        check("async reset out_valid", 32'(out_valid), 32'(0));
        check("async reset busy",      32'(busy),      32'(0));
        check("async reset s",         32'(s),         32'(0));
        check("async reset cout",      32'(cout),      32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post-reset in_ready", 32'(in_ready), 32'(1));
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002, "add_after_reset");

        // Back-to-back operations: one result every N+2 cycles.
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        dones = 0;
        for (int i = 1; i <= 3 * (N + 2); i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                dones++;
                check("throughput result", 32'({cout, s}), 32'(17'h03333));
            end
        end
        in_valid = 1'b0;
        check("throughput done count", 32'(dones), 32'(3));

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, "sub_5_minus_7");
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, "sub_7_minus_5");
        do_op(16'h0007, 16'h0007, 1'b1, 1'b1, 17'h0FFFF, "sub_7_minus_7_b1");
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, "add_with_sub_build");
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chunk_serial_adder.md
CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, else elaboration error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands and cin valid.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 a  input  WIDTH  addend.
REQ-008 b  input  WIDTH  addend.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 s  output  WIDTH  sum.
REQ-013 cout  output  1  carry-out.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 FSM SHALL have states IDLE, RUN and DONE; reset state IDLE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready edge, capture a, b, cin into registers, clear chunk counter and s register, go to RUN.
REQ-017 RUN: each cycle, add chunk k (bits k*CHUNK+CHUNK-1:k*CHUNK) of the captured a and b plus the carry register, write the sum into chunk k of s, store carry-out in the carry register, increment k.
REQ-018 After chunk N-1 (N=WIDTH/CHUNK), go to DONE, cout=final carry; out_valid high exactly N cycles after the accepting edge.
REQ-019 DONE: out_valid=1, s and cout held stable until out_valid&out_ready edge, then go to IDLE; in_ready returns one cycle after the handshake.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid ignored there, so no operation overlap.
REQ-021 {cout,s} SHALL equal a+b+cin for all operands (WIDTH+1-bit exact result).
REQ-022 s reads 0 and out_valid 0 outside DONE is not required for s; s SHALL be valid only while out_valid=1; cout SHALL be 0 outside DONE.
REQ-023 Throughput: one operation per N+2 cycles when out_ready is held high.
REQ-024 CHUNK=WIDTH SHALL work (N=1, single RUN cycle).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, s=0, cout=0, counter=0, carry=0, regardless of state; an in-flight operation is discarded without output.

Configuration
REQ-026 Macro CHUNK_SERIAL_ADDER_SUB_EN: when defined, add input port sub (1 bit), captured with the operands; sub=1 SHALL compute s=(a-b-cin) mod 2^WIDTH via a+~b+!cin, with cout=1 meaning no borrow (a>=b+cin); sub=0 is the add behaviour.
REQ-027 Macro undefined: no sub port, add only, no subtract logic present.

Structure
REQ-028 Package chunk_serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE).
REQ-029 Sub-module full_adder_nbit SHALL hold the combinational CHUNK-bit adder (a, b, cin -> s, cout), instantiated once and reused every RUN cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-030 0x1234+0x4321, cin=0 -> s=0x5555, cout=0, out_valid exactly 4 cycles after accept.
REQ-031 0xFFFF+0x0001, cin=0 -> s=0x0000, cout=1 (carry through all chunks).
REQ-032 0xFFFF+0xFFFF, cin=1 -> s=0xFFFF, cout=1.
REQ-033 out_ready low for 5 cycles in DONE -> s, cout, out_valid stable, in_ready=0, a new in_valid pulse not accepted.
REQ-034 rst_n low on the 2nd RUN cycle -> all outputs at reset values at once; after release, in_ready=1 and the next operation 0x0001+0x0001 gives 0x0002.
REQ-035 With CHUNK_SERIAL_ADDER_SUB_EN: 0x0005-0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0; 0x0007-0x0005 -> s=0x0002, cout=1.
